// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared definitions for the CompactRISC16 register file.
//   addr_width(depth) : number of address bits needed to index 'depth' entries,
//                       never less than 1.
//   ZERO_ADDR         : index of the optionally hard-wired zero entry.
// -----------------------------------------------------------------------------
package register_file_pkg;

  localparam int ZERO_ADDR = 0;

  // ceil(log2(depth)), clamped to a minimum of 1 so a 1- or 2-entry file
  // still has a real address bit.
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// -----------------------------------------------------------------------------
// register_file_read_port
// One registered read port of the register file. It picks the value for the
// addressed entry (with illegal-address, zero-entry and write-bypass handling)
// and captures it into the output flop when the read strobe is high.
//
// Ports:
//   clk_i, rst_ni   clock / asynchronous active-low reset
//   entries_i       current contents of every storage entry
//   wr_qual_i       a qualifying write is being presented this cycle
//   wr_addr_i       write address
//   wr_data_i       write data
//   rd_en_i         read strobe
//   rd_addr_i       read address
//   rd_data_o       registered read data (holds when rd_en_i is low)
//   rd_valid_o      high for the one cycle after a read strobe
//
// Strobe semantics: there is no back-pressure. A read strobe sampled high on a
// rising edge always completes; rd_valid_o is high exactly in the cycle that
// follows, and rd_data_o is only refreshed on those edges.
// -----------------------------------------------------------------------------
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int P_WIDTH    = 16,
  parameter int P_DEPTH    = 16,
  parameter int P_ZERO_REG = 0,
  parameter int P_BYPASS   = 1,
  parameter int P_ADDR_W   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [P_WIDTH-1:0]  entries_i [P_DEPTH],
  input  logic                wr_qual_i,
  input  logic [P_ADDR_W-1:0] wr_addr_i,
  input  logic [P_WIDTH-1:0]  wr_data_i,
  input  logic                rd_en_i,
  input  logic [P_ADDR_W-1:0] rd_addr_i,
  output logic [P_WIDTH-1:0]  rd_data_o,
  output logic                rd_valid_o
);

  localparam logic [31:0] DEPTH_U = P_DEPTH;

  logic               rd_legal;
  logic               rd_is_zero;
  logic               bypass_hit;
  logic [P_WIDTH-1:0] entry_val;
  logic [P_WIDTH-1:0] sel_val;

  logic [P_WIDTH-1:0] data_d;
  logic [P_WIDTH-1:0] data_q;
  logic               valid_d;
  logic               valid_q;

  // Widen the address before comparing so a non-power-of-two depth catches
  // the unused top codes.
  assign rd_legal   = ({{(32-P_ADDR_W){1'b0}}, rd_addr_i} < DEPTH_U);
  assign rd_is_zero = (P_ZERO_REG != 0) && (rd_addr_i == P_ADDR_W'(ZERO_ADDR));
  assign bypass_hit = (P_BYPASS != 0) && wr_qual_i && (wr_addr_i == rd_addr_i);

  // Decoded mux instead of a direct array index so out-of-range codes never
  // index past the end of the storage.
  always_comb begin
    entry_val = '0;
    for (int i = 0; i < P_DEPTH; i++) begin
      if (rd_addr_i == P_ADDR_W'(i)) begin
        entry_val = entries_i[i];
      end
    end
  end

  // Priority: illegal address, then hard-wired zero, then bypass, then storage.
  always_comb begin
    sel_val = entry_val;
    if (!rd_legal) begin
      sel_val = '0;
    end else if (rd_is_zero) begin
      sel_val = '0;
    end else if (bypass_hit) begin
      sel_val = wr_data_i;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = rd_en_i;
    if (rd_en_i) begin
      data_d = sel_val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;

endmodule : register_file_read_port

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// Multi-entry register storage for the CompactRISC16 datapath: one write port
// (from writeback) and two independent registered read ports (A/B operand
// latches). Reads have one cycle of latency; a same-cycle write to the read
// address can optionally be forwarded, and entry 0 can be hard-wired to zero.
//
// Ports:
//   I_CLK            clock, rising edge
//   I_NRESET         asynchronous active-low reset (clears storage + outputs)
//   I_WRITE_ENABLE   write strobe
//   I_WRITE_ADDR     write address
//   I_WRITE_DATA     write data
//   I_READ_ENABLE_A  read strobe, port A
//   I_READ_ADDR_A    read address, port A
//   O_READ_DATA_A    registered read data, port A
//   O_READ_VALID_A   port A data refreshed this cycle
//   I_READ_ENABLE_B, I_READ_ADDR_B, O_READ_DATA_B, O_READ_VALID_B  as port A
//
// Writes that target an illegal address, or entry 0 when it is hard-wired,
// are dropped without any indication.
// -----------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
#(
  parameter  int P_WIDTH    = 16,
  parameter  int P_DEPTH    = 16,
  parameter  int P_ZERO_REG = 0,
  parameter  int P_BYPASS   = 1,
  localparam int P_ADDR_W   = addr_width(P_DEPTH)
) (
  input  logic                I_CLK,
  input  logic                I_NRESET,
  input  logic                I_WRITE_ENABLE,
  input  logic [P_ADDR_W-1:0] I_WRITE_ADDR,
  input  logic [P_WIDTH-1:0]  I_WRITE_DATA,
  input  logic                I_READ_ENABLE_A,
  input  logic [P_ADDR_W-1:0] I_READ_ADDR_A,
  output logic [P_WIDTH-1:0]  O_READ_DATA_A,
  output logic                O_READ_VALID_A,
  input  logic                I_READ_ENABLE_B,
  input  logic [P_ADDR_W-1:0] I_READ_ADDR_B,
  output logic [P_WIDTH-1:0]  O_READ_DATA_B,
  output logic                O_READ_VALID_B
);

  localparam logic [31:0] DEPTH_U = P_DEPTH;

  logic [P_WIDTH-1:0] mem_d [P_DEPTH];
  logic [P_WIDTH-1:0] mem_q [P_DEPTH];

  logic wr_legal;
  logic wr_to_zero;
  logic wr_qual;

  // ---------------------------------------------------------------------------
  // Write qualification and decode
  // ---------------------------------------------------------------------------
  assign wr_legal   = ({{(32-P_ADDR_W){1'b0}}, I_WRITE_ADDR} < DEPTH_U);
  assign wr_to_zero = (P_ZERO_REG != 0) && (I_WRITE_ADDR == P_ADDR_W'(ZERO_ADDR));
  assign wr_qual    = I_WRITE_ENABLE && wr_legal && !wr_to_zero;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < P_DEPTH; i++) begin
      if (wr_qual && (I_WRITE_ADDR == P_ADDR_W'(i))) begin
        mem_d[i] = I_WRITE_DATA;
      end
    end
  end

  // Entry 0 in zero-register mode is never written, so it stays at its reset
  // value of 0 without a special case here.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      for (int i = 0; i < P_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  register_file_read_port #(
    .P_WIDTH    (P_WIDTH),
    .P_DEPTH    (P_DEPTH),
    .P_ZERO_REG (P_ZERO_REG),
    .P_BYPASS   (P_BYPASS),
    .P_ADDR_W   (P_ADDR_W)
  ) u_read_port_a (
    .clk_i      (I_CLK),
    .rst_ni     (I_NRESET),
    .entries_i  (mem_q),
    .wr_qual_i  (wr_qual),
    .wr_addr_i  (I_WRITE_ADDR),
    .wr_data_i  (I_WRITE_DATA),
    .rd_en_i    (I_READ_ENABLE_A),
    .rd_addr_i  (I_READ_ADDR_A),
    .rd_data_o  (O_READ_DATA_A),
    .rd_valid_o (O_READ_VALID_A)
  );

  register_file_read_port #(
    .P_WIDTH    (P_WIDTH),
    .P_DEPTH    (P_DEPTH),
    .P_ZERO_REG (P_ZERO_REG),
    .P_BYPASS   (P_BYPASS),
    .P_ADDR_W   (P_ADDR_W)
  ) u_read_port_b (
    .clk_i      (I_CLK),
    .rst_ni     (I_NRESET),
    .entries_i  (mem_q),
    .wr_qual_i  (wr_qual),
    .wr_addr_i  (I_WRITE_ADDR),
    .wr_data_i  (I_WRITE_DATA),
    .rd_en_i    (I_READ_ENABLE_B),
    .rd_addr_i  (I_READ_ADDR_B),
    .rd_data_o  (O_READ_DATA_B),
    .rd_valid_o (O_READ_VALID_B)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Two register_file instances share one stimulus stream:
//   dut0 : 16 entries, no zero register, bypass on
//   dut1 : 12 entries, zero register on, bypass off
// A directed vector table covers the reset, write/read, bypass, zero-entry and
// illegal-address cases, a hand-written sequence covers asynchronous reset
// during a write, and a random phase is checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_register_file;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Stimulus and DUT outputs
  // ---------------------------------------------------------------------------
  logic        we;
  logic [3:0]  wa;
  logic [15:0] wd;
  logic        rea;
  logic [3:0]  raa;
  logic        reb;
  logic [3:0]  rab;

  logic [15:0] d_a0, d_b0, d_a1, d_b1;
  logic        v_a0, v_b0, v_a1, v_b1;

  register_file #(
    .P_WIDTH(16), .P_DEPTH(16), .P_ZERO_REG(0), .P_BYPASS(1)
  ) dut0 (
    .I_CLK(clk), .I_NRESET(rst_n),
    .I_WRITE_ENABLE(we), .I_WRITE_ADDR(wa), .I_WRITE_DATA(wd),
    .I_READ_ENABLE_A(rea), .I_READ_ADDR_A(raa),
    .O_READ_DATA_A(d_a0), .O_READ_VALID_A(v_a0),
    .I_READ_ENABLE_B(reb), .I_READ_ADDR_B(rab),
    .O_READ_DATA_B(d_b0), .O_READ_VALID_B(v_b0)
  );

  register_file #(
    .P_WIDTH(16), .P_DEPTH(12), .P_ZERO_REG(1), .P_BYPASS(0)
  ) dut1 (
    .I_CLK(clk), .I_NRESET(rst_n),
    .I_WRITE_ENABLE(we), .I_WRITE_ADDR(wa), .I_WRITE_DATA(wd),
    .I_READ_ENABLE_A(rea), .I_READ_ADDR_A(raa),
    .O_READ_DATA_A(d_a1), .O_READ_VALID_A(v_a1),
    .I_READ_ENABLE_B(reb), .I_READ_ADDR_B(rab),
    .O_READ_DATA_B(d_b1), .O_READ_VALID_B(v_b1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model: a plain array per instance plus the rules for
  // which value a read returns.
  // ---------------------------------------------------------------------------
  int          m_depth [2] = '{16, 12};
  int          m_zero  [2] = '{0, 1};
  int          m_byp   [2] = '{1, 0};
  logic [15:0] m_mem   [2][16];
  logic [15:0] m_data  [2][2];
  logic        m_valid [2][2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int e = 0; e < 16; e++) m_mem[k][e] = 16'h0;
      for (int p = 0; p < 2; p++) begin
        m_data[k][p]  = 16'h0;
        m_valid[k][p] = 1'b0;
      end
    end
  endtask

  // Called with the inputs that will be sampled on the next rising edge.
  task automatic model_step();
    int   ra;
    logic re;
    logic qual;
    for (int k = 0; k < 2; k++) begin
      qual = we && (int'(wa) < m_depth[k]) && !(m_zero[k] != 0 && wa == 4'd0);
      for (int p = 0; p < 2; p++) begin
        re = (p == 0) ? rea : reb;
        ra = (p == 0) ? int'(raa) : int'(rab);
        if (re) begin
          if (ra >= m_depth[k])                             m_data[k][p] = 16'h0;
          else if (m_zero[k] != 0 && ra == 0)               m_data[k][p] = 16'h0;
          else if (m_byp[k] != 0 && qual && int'(wa) == ra) m_data[k][p] = wd;
          else                                              m_data[k][p] = m_mem[k][ra];
          m_valid[k][p] = 1'b1;
        end else begin
          m_valid[k][p] = 1'b0;
        end
      end
      if (qual) m_mem[k][int'(wa)] = wd;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic we_t, input logic [3:0] wa_t, input logic [15:0] wd_t,
                       input logic rea_t, input logic [3:0] raa_t,
                       input logic reb_t, input logic [3:0] rab_t);
    we  = we_t;  wa  = wa_t;  wd  = wd_t;
    rea = rea_t; raa = raa_t;
    reb = reb_t; rab = rab_t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_all(input string tag);
    check({tag, " dut0 A data"}, d_a0, 16'h0);
    check({tag, " dut0 B data"}, d_b0, 16'h0);
    check({tag, " dut1 A data"}, d_a1, 16'h0);
    check({tag, " dut1 B data"}, d_b1, 16'h0);
    check({tag, " dut0 A valid"}, {15'h0, v_a0}, 16'h0);
    check({tag, " dut0 B valid"}, {15'h0, v_b0}, 16'h0);
    check({tag, " dut1 A valid"}, {15'h0, v_a1}, 16'h0);
    check({tag, " dut1 B valid"}, {15'h0, v_b1}, 16'h0);
  endtask

  task automatic check_model(input string tag);
    check({tag, " dut0 A data"}, d_a0, m_data[0][0]);
    check({tag, " dut0 B data"}, d_b0, m_data[0][1]);
    check({tag, " dut1 A data"}, d_a1, m_data[1][0]);
    check({tag, " dut1 B data"}, d_b1, m_data[1][1]);
    check({tag, " dut0 A valid"}, {15'h0, v_a0}, {15'h0, m_valid[0][0]});
    check({tag, " dut1 B valid"}, {15'h0, v_b1}, {15'h0, m_valid[1][1]});
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        rea;
    logic [3:0]  raa;
    logic        reb;
    logic [3:0]  rab;
    logic [15:0] ea0;
    logic [15:0] eb0;
    logic [15:0] ea1;
    logic [15:0] eb1;
    logic        eva;
    logic        evb;
  } vec_t;

  localparam int N_VEC = 12;
  vec_t vecs [N_VEC];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // dut0 = 16 entries/bypass, dut1 = 12 entries/zero-reg/no bypass
    vecs[0]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  1'b1, 4'd15, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 4'd5,  16'hBEEF, 1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  1'b0, 4'd0,  16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b0, 4'd0,  16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd7,  16'hBEEF, 1'b0, 4'd0,  1'b0, 4'd0,  16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd7,  16'h1234, 1'b1, 4'd7,  1'b0, 4'd0,  16'h1234, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd7,  1'b0, 4'd0,  16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd0,  16'hFFFF, 1'b1, 4'd0,  1'b1, 4'd0,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd0,  1'b1, 4'd0,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 4'd13, 16'hAAAA, 1'b1, 4'd13, 1'b1, 4'd13, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd13, 1'b1, 4'd12, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  1'b1, 4'd7,  16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234, 1'b1, 1'b1};

    // ---- reset ----
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check_zero_all("reset");
    rst_n = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < N_VEC; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rea, vecs[i].raa, vecs[i].reb, vecs[i].rab);
      step();
      check($sformatf("vec%0d dut0 A data", i), d_a0, vecs[i].ea0);
      check($sformatf("vec%0d dut0 B data", i), d_b0, vecs[i].eb0);
      check($sformatf("vec%0d dut1 A data", i), d_a1, vecs[i].ea1);
      check($sformatf("vec%0d dut1 B data", i), d_b1, vecs[i].eb1);
      check($sformatf("vec%0d dut0 A valid", i), {15'h0, v_a0}, {15'h0, vecs[i].eva});
      check($sformatf("vec%0d dut0 B valid", i), {15'h0, v_b0}, {15'h0, vecs[i].evb});
      check($sformatf("vec%0d dut1 A valid", i), {15'h0, v_a1}, {15'h0, vecs[i].eva});
      check($sformatf("vec%0d dut1 B valid", i), {15'h0, v_b1}, {15'h0, vecs[i].evb});
    end

    // ---- asynchronous reset in the middle of a write ----
    drive(1'b1, 4'd2, 16'h5555, 1'b1, 4'd2, 1'b1, 4'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_all("async reset");
    step();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    rst_n = 1'b1;
    model_reset();

    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b1, 4'd5);
    model_step();
    step();
    check("post-reset dut0 read 2", d_a0, 16'h0000);
    check("post-reset dut1 read 2", d_a1, 16'h0000);
    check("post-reset dut0 read 5", d_b0, 16'h0000);
    check_model("post-reset");

    // First edge after release must accept a write.
    drive(1'b1, 4'd3, 16'h7777, 1'b0, 4'd0, 1'b0, 4'd0);
    model_step();
    step();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b1, 4'd3);
    model_step();
    step();
    check("first write dut0 A", d_a0, 16'h7777);
    check("first write dut1 B", d_b1, 16'h7777);
    check_model("first write");

    // ---- randomized stimulus against the model ----
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            16'($urandom),
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
      model_step();
      exp_q.push_back(m_data[0][0]);
      exp_q.push_back(m_data[0][1]);
      exp_q.push_back(m_data[1][0]);
      exp_q.push_back(m_data[1][1]);
      exp_q.push_back({14'h0, m_valid[0][0], m_valid[0][1]});
      exp_q.push_back({14'h0, m_valid[1][0], m_valid[1][1]});
      step();
      check("rand dut0 A data", d_a0, exp_q.pop_front());
      check("rand dut0 B data", d_b0, exp_q.pop_front());
      check("rand dut1 A data", d_a1, exp_q.pop_front());
      check("rand dut1 B data", d_b1, exp_q.pop_front());
      check("rand dut0 valid", {14'h0, v_a0, v_b0}, exp_q.pop_front());
      check("rand dut1 valid", {14'h0, v_a1, v_b1}, exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- Parametrised multi-entry register storage for the CompactRISC16 datapath.
- One write port and two read ports, with registered (1-cycle) reads and optional write-to-read bypass.
- Entry 0 can optionally be hard-wired to zero.
- Sits between decode and the ALU; the A/B read ports feed the operand latches, and the write port is driven by writeback.

Parameters:
P_WIDTH, 16, data width of each entry in bits
P_DEPTH, 16, number of entries (>= 2; need not be a power of two)
P_ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes
P_BYPASS, 1, 1 = a read of the address being written in the same cycle returns the new data

Ports:
I_CLK  input  1  clock, all state updates on rising edge
I_NRESET  input  1  reset, asynchronous, active-low
I_WRITE_ENABLE  input  1  write strobe
I_WRITE_ADDR  input  P_ADDR_W  write address
I_WRITE_DATA  input  P_WIDTH  write data
I_READ_ENABLE_A  input  1  read strobe, port A
I_READ_ADDR_A  input  P_ADDR_W  read address, port A
O_READ_DATA_A  output  P_WIDTH  registered read data, port A
O_READ_VALID_A  output  1  port A data updated this cycle
I_READ_ENABLE_B, I_READ_ADDR_B, O_READ_DATA_B, O_READ_VALID_B  same as port A, for port B

Behaviour:
- Clock and reset: one clock, I_CLK. Reset I_NRESET is asynchronous and active-low.
- Address width: P_ADDR_W = max(1, ceil(log2(P_DEPTH))).
- Legal address: addr < P_DEPTH.
- Reset (I_NRESET = 0, asynchronous, takes effect immediately):
  - all entries = 0;
  - O_READ_DATA_A/B = 0;
  - O_READ_VALID_A/B = 0.
  - Reset overrides every strobe, and a write in flight at reset assertion is discarded.
  - First write is accepted on the first rising edge with I_NRESET = 1.
- Write:
  - Qualifying write: I_WRITE_ENABLE = 1, I_WRITE_ADDR legal, and not (P_ZERO_REG = 1 and address 0).
  - On the rising edge, entry[I_WRITE_ADDR] <= I_WRITE_DATA.
  - Any non-qualifying write is a silent no-op.
- Read, per port, latency 1 cycle:
  - If I_READ_ENABLE_x = 1 on the rising edge, O_READ_DATA_x <= selected value and O_READ_VALID_x <= 1.
  - Otherwise O_READ_DATA_x holds its value and O_READ_VALID_x <= 0.
- Selected value, priority order:
  1. 0 if the read address is illegal;
  2. 0 if P_ZERO_REG = 1 and the read address is 0;
  3. I_WRITE_DATA if P_BYPASS = 1, a qualifying write is present, and I_WRITE_ADDR equals the read address;
  4. otherwise the entry contents before the edge.
- P_BYPASS = 0: a same-cycle read of the write address returns the old value; the new value is visible on the next read.
- Both ports may read the same address simultaneously, and each sees identical data.
- Ports A and B are fully independent; no arbitration is needed.
- No combinational path exists from any input to any output; all outputs are registered.

Decomposition:
- Package register_file_pkg:
  - function addr_width(depth);
  - localparam ZERO_ADDR = 0.
- Sub-module register_file_read_port, instantiated twice (A, B):
  - inputs: entry array, write-port signals, the read enable/address for that port;
  - contains the bypass/zero/illegal select and the output data and valid flops;
  - parameters passed through from the top.
- Top level holds the storage array and write decode.

Test Plan:
- Reset then read: release I_NRESET, read A = 3 and B = 15 -> next cycle both data = 0x0000, both valid = 1.
- Write then read: write 0xBEEF to 5, next cycle read A = 5 -> 0xBEEF one cycle after the read strobe. With the read enable low thereafter, data holds 0xBEEF and valid = 0.
- Bypass, P_BYPASS = 1: write 0x1234 to 7 and read A = 7 in the same cycle -> A = 0x1234.
- Bypass disabled, P_BYPASS = 0: repeat the previous scenario -> A = old value 0xBEEF first, then 0x1234 on the next read.
- Zero register, P_ZERO_REG = 1: write 0xFFFF to 0, read A = 0 and B = 0 -> both 0x0000. With P_ZERO_REG = 0 -> both 0xFFFF.
- Illegal address and async reset: with P_DEPTH = 12, write 0xAAAA to 13 and read 13 -> 0x0000 and no entry changes. Then assert I_NRESET mid-cycle during a write of 0x5555 to 2 -> outputs go to 0 immediately, and a read of 2 after release -> 0x0000.
